// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: data-memory access controller for the MEM stage.
// Issues ready-handshaked requests, stalls upstream, flags faults, retires halt.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_EX_MEM,
  input  logic        mem_wr_EX_MEM,
  input  logic [15:0] alu_out_EX_MEM,
  input  logic [15:0] writedata_EX_MEM,
  input  logic        halt_EX_MEM,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_rdy,
  input  logic [15:0] mem_rdata,
  output logic        stall_MEM,
  output logic [15:0] rd_data_MEM,
  output logic        rd_valid_MEM,
  output logic        err_MEM,
  output logic        halt_done
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;
  logic        err_q;
  logic        halt_q;

  logic issue;
  logic busy;
  logic accept_ld;

  // Request/stall decode; gated by reset so they drop asynchronously.
  always_comb begin
    issue = (state_q == IDLE) & mem_en_EX_MEM
          & ~alu_out_EX_MEM[0] & ~halt_q;
    busy = issue | (state_q == REQ);
    mem_req = rst & busy;
    stall_MEM = rst & (busy | (state_q == ERR));
    mem_wr = mem_req & mem_wr_EX_MEM;
    mem_addr = mem_req ? alu_out_EX_MEM : 16'h0;
    mem_wdata = mem_req ? writedata_EX_MEM : 16'h0;
    accept_ld = mem_req & mem_rdy & ~mem_wr_EX_MEM;
  end

  // Access FSM with wait counter, load capture and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'h0;
      rd_data_q  <= 16'h0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (accept_ld) begin
        rd_data_q  <= mem_rdata;
        rd_valid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          cnt_q <= 8'h0;
          if (mem_en_EX_MEM && !halt_q) begin
            if (alu_out_EX_MEM[0]) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else if (mem_rdy) begin
              state_q <= DONE;
            end else begin
              state_q <= REQ;
            end
          end else if (halt_EX_MEM) begin
            halt_q <= 1'b1;
          end
        end
        REQ: begin
          if (mem_rdy) begin
            state_q <= DONE;
            cnt_q   <= 8'h0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            cnt_q   <= 8'h0;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= 8'h0;
          if (halt_EX_MEM) halt_q <= 1'b1;
        end
        default: begin
          cnt_q <= 8'h0;
        end
      endcase
    end
  end

  assign rd_data_MEM  = rd_data_q;
  assign rd_valid_MEM = rd_valid_q;
  assign err_MEM      = err_q;
  assign halt_done    = halt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: transaction-level checks of mem_stage_ctrl.
// Expected cycles derive from wait count vs TIMEOUT arithmetic.
module tb_mem_stage_ctrl;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic        mem_en_EX_MEM;
  logic        mem_wr_EX_MEM;
  logic [15:0] alu_out_EX_MEM;
  logic [15:0] writedata_EX_MEM;
  logic        halt_EX_MEM;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rdy;
  logic [15:0] mem_rdata;
  logic        stall_MEM;
  logic [15:0] rd_data_MEM;
  logic        rd_valid_MEM;
  logic        err_MEM;
  logic        halt_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_rd;
  logic        exp_err;
  logic        exp_halt;

  mem_stage_ctrl #(.TIMEOUT(T)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_en_EX_MEM    (mem_en_EX_MEM),
    .mem_wr_EX_MEM    (mem_wr_EX_MEM),
    .alu_out_EX_MEM   (alu_out_EX_MEM),
    .writedata_EX_MEM (writedata_EX_MEM),
    .halt_EX_MEM      (halt_EX_MEM),
    .mem_req          (mem_req),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdy          (mem_rdy),
    .mem_rdata        (mem_rdata),
    .stall_MEM        (stall_MEM),
    .rd_data_MEM      (rd_data_MEM),
    .rd_valid_MEM     (rd_valid_MEM),
    .err_MEM          (err_MEM),
    .halt_done        (halt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, ".req"}, mem_req, 0);
    chk({tag, ".wr"}, mem_wr, 0);
    chk({tag, ".addr"}, mem_addr, 0);
    chk({tag, ".wdata"}, mem_wdata, 0);
  endtask

  task automatic chk_flags(input string tag, input logic rv);
    chk({tag, ".rvalid"}, rd_valid_MEM, rv);
    chk({tag, ".rdata"}, rd_data_MEM, exp_rd);
    chk({tag, ".err"}, err_MEM, exp_err);
    chk({tag, ".halt"}, halt_done, exp_halt);
  endtask

  task automatic err_cycles();
    exp_err = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mem_rdy = 1'($urandom);
      @(negedge clk);
      chk_idle_bus("err");
      chk("err.stall", stall_MEM, 1);
      chk_flags("err", 1'b0);
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk_idle_bus("rst");
    chk("rst.stall", stall_MEM, 0);
    chk("rst.rvalid", rd_valid_MEM, 0);
    chk("rst.rdata", rd_data_MEM, 0);
    chk("rst.err", err_MEM, 0);
    chk("rst.halt", halt_done, 0);
    mem_en_EX_MEM = 1'b0;
    halt_EX_MEM   = 1'b0;
    mem_rdy       = 1'b0;
    exp_rd   = 16'h0;
    exp_err  = 1'b0;
    exp_halt = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // One IDLE cycle; en only meaningful once halted (must be ignored).
  task automatic idle(input bit h, input bit en);
    mem_en_EX_MEM    = en;
    mem_wr_EX_MEM    = 1'($urandom);
    alu_out_EX_MEM   = 16'($urandom);
    writedata_EX_MEM = 16'($urandom);
    halt_EX_MEM      = h;
    mem_rdy          = 1'($urandom);
    @(negedge clk);
    chk_idle_bus("idle");
    chk("idle.stall", stall_MEM, 0);
    chk_flags("idle", 1'b0);
    step();
    if (h) exp_halt = 1'b1;
  endtask

  // One access whose memory answers after w wait cycles.
  task automatic access(input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd,
                        input int w, input bit h);
    int n;
    mem_en_EX_MEM    = 1'b1;
    mem_wr_EX_MEM    = wr;
    alu_out_EX_MEM   = a;
    writedata_EX_MEM = wd;
    halt_EX_MEM      = h;
    if (a[0]) begin
      mem_rdy = 1'($urandom);
      @(negedge clk);
      chk("unal.req", mem_req, 0);
      step();
      err_cycles();
      return;
    end
    n = (w <= T) ? w : T;
    for (int i = 0; i <= n; i++) begin
      mem_rdy   = (i == w);
      mem_rdata = (i == w) ? rd : 16'($urandom);
      @(negedge clk);
      chk("acc.req", mem_req, 1);
      chk("acc.stall", stall_MEM, 1);
      chk("acc.wr", mem_wr, 16'(wr));
      chk("acc.addr", mem_addr, a);
      chk("acc.wdata", mem_wdata, wd);
      chk_flags("acc", 1'b0);
      step();
    end
    if (w <= T) begin
      if (!wr) exp_rd = rd;
      mem_rdy   = 1'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      chk_idle_bus("done");
      chk("done.stall", stall_MEM, 0);
      chk_flags("done", !wr);
      step();
      if (h) exp_halt = 1'b1;
    end else begin
      err_cycles();
    end
  endtask

  initial begin
    int r;
    logic [15:0] a;
    rst = 1'b0;
    mem_en_EX_MEM = 0; mem_wr_EX_MEM = 0; alu_out_EX_MEM = 0;
    writedata_EX_MEM = 0; halt_EX_MEM = 0; mem_rdy = 0; mem_rdata = 0;
    exp_rd = 0; exp_err = 0; exp_halt = 0;
    #2;
    chk_idle_bus("reset");
    chk("reset.stall", stall_MEM, 0);
    chk_flags("reset", 1'b0);
    step();
    rst = 1'b1;

    access(1'b0, 16'h0010, 16'h0, 16'hBEEF, 0, 1'b0);
    idle(1'b0, 1'b0);
    access(1'b1, 16'h0100, 16'h1234, 16'h0, 3, 1'b0);
    access(1'b0, 16'h0020, 16'h0, 16'hA5A5, 0, 1'b0);
    access(1'b0, 16'h0022, 16'h0, 16'h5A5A, 0, 1'b0);
    access(1'b1, 16'h0050, 16'h7777, 16'h0, T, 1'b0);
    access(1'b0, 16'h0040, 16'h0, 16'h1111, T + 1, 1'b0);
    do_reset();
    access(1'b0, 16'h0003, 16'h0, 16'h2222, 0, 1'b0);
    do_reset();
    idle(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0, 1'b1);
    do_reset();
    access(1'b0, 16'h0060, 16'h0, 16'hCAFE, 1, 1'b1);
    idle(1'b0, 1'b1);
    do_reset();

    mem_en_EX_MEM = 1'b1; mem_wr_EX_MEM = 1'b0;
    alu_out_EX_MEM = 16'h0070; mem_rdy = 1'b0;
    @(negedge clk);
    chk("mid.req0", mem_req, 1);
    step();
    @(negedge clk);
    chk("mid.req1", mem_req, 1);
    do_reset();

    for (int it = 0; it < 60; it++) begin
      if (exp_err || exp_halt) do_reset();
      r = $urandom_range(0, 19);
      a = 16'($urandom);
      if (r == 0) begin
        access(1'b0, a | 16'h1, 16'h0, 16'h0, 0, 1'b0);
      end else if (r == 1) begin
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
      end else if (r < 4) begin
        idle(1'b0, 1'b0);
      end else begin
        access(1'($urandom), a & 16'hFFFE, 16'($urandom),
               16'($urandom), $urandom_range(0, T + 1),
               ($urandom_range(0, 7) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and performs the data-memory access they describe. It drives a ready-handshaked data memory and returns read data to the MEM/WB path. It stalls the upstream pipeline for the duration of each access and flags unaligned or timed-out accesses. It also retires the halt indication once no memory access is outstanding.

## Interface
- TIMEOUT, 15: cycles an access may wait for `mem_rdy` in REQ before aborting to ERR; range 1..255.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mem_en_EX_MEM  in  1  instruction in EX/MEM accesses data memory.
- mem_wr_EX_MEM  in  1  1 = store, 0 = load; valid when `mem_en_EX_MEM`=1.
- alu_out_EX_MEM  in  16  byte address of the access.
- writedata_EX_MEM  in  16  store data.
- halt_EX_MEM  in  1  instruction in EX/MEM is HALT.
- mem_req  out  1  access request to data memory.
- mem_wr  out  1  write strobe qualified by `mem_req`.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdy  in  1  memory completes the current request this cycle.
- mem_rdata  in  16  read data; valid when `mem_rdy`=1 and `mem_wr`=0.
- stall_MEM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- rd_data_MEM  out  16  registered load result.
- rd_valid_MEM  out  1  one-cycle pulse: `rd_data_MEM` holds new load data.
- err_MEM  out  1  sticky: unaligned address or timeout.
- halt_done  out  1  sticky: halt retired.

## Operation
- The FSM has four states: IDLE, REQ, DONE and ERR. Reset state is IDLE.
- IDLE, no `mem_en_EX_MEM`, no halt: all outputs are idle and the pipeline flows.
- IDLE with `mem_en_EX_MEM`=1 and `alu_out_EX_MEM[0]`=1 (unaligned): the controller goes to ERR. No request is issued.
- IDLE with `mem_en_EX_MEM`=1, aligned, and `halt_done`=0:
  - `mem_req`=1 and `stall_MEM`=1 combinationally in the same cycle.
  - If `mem_rdy`=1 in that cycle, the next state is DONE. Otherwise the next state is REQ.
- REQ: `mem_req`=1 and `stall_MEM`=1.
  - `mem_rdy`=1 moves to DONE.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT, the next state is ERR.
- On each accepted load (`mem_req & mem_rdy & ~mem_wr`), `rd_data_MEM` registers `mem_rdata`.
- DONE:
  - `stall_MEM`=0 and `mem_req`=0. The EX/MEM register still holds the same access, and the controller does not re-issue it.
  - `rd_valid_MEM`=1 for loads only.
  - The next state is always IDLE.
- ERR: `err_MEM`=1, `stall_MEM`=1 and `mem_req`=0. The controller holds ERR until reset.
- `mem_wr`, `mem_addr` and `mem_wdata` equal `mem_wr_EX_MEM`, `alu_out_EX_MEM` and `writedata_EX_MEM` while `mem_req`=1. Otherwise they are 0.
- Halt:
  - `halt_EX_MEM`=1 sampled in IDLE sets `halt_done` on the next edge.
  - `halt_done` stays set until reset.
  - Once `halt_done`=1, `mem_en_EX_MEM` is ignored.
  - HALT carries no memory access. If `halt_EX_MEM` and `mem_en_EX_MEM` are both 1, the access completes first and `halt_done` sets on the edge leaving DONE.
- The wait counter is 8 bits. It clears on entry to REQ and in every non-REQ state, and it saturates and never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset asserted mid-access: the controller returns to IDLE immediately and `mem_req` drops asynchronously.
- Minimum access cost is two cycles (issue plus DONE) with a zero-wait memory. Each wait cycle adds one stall cycle.
- `rd_data_MEM` and `rd_valid_MEM` are valid in the DONE cycle, one edge after `mem_rdy`.
- `stall_MEM` is combinational from state and EX/MEM inputs. It never depends on `mem_rdy`.
- Back-to-back accesses: a new access is issued in the IDLE cycle directly after DONE, with no gap beyond DONE.
- Timeout: with `mem_rdy` stuck at 0, ERR is entered on the edge that ends the TIMEOUT-th REQ cycle.

## Test plan
- Zero-wait load: `mem_rdy`=1 when `mem_req` is issued, addr 0x0010, `mem_rdata`=0xBEEF → `stall_MEM` high for one cycle, then DONE with `rd_valid_MEM`=1 and `rd_data_MEM`=0xBEEF. No second request.
- Store with 3 wait cycles: addr 0x0100, data 0x1234 → `mem_req`, `mem_wr`=1 and `mem_wdata`=0x1234 held for 4 cycles, `stall_MEM` high for 4 cycles, DONE with `rd_valid_MEM`=0.
- Unaligned load at 0x0003 → `mem_req` never asserted, `err_MEM`=1 and `stall_MEM`=1 from the next cycle, both persisting.
- Timeout: TIMEOUT=4 with `mem_rdy` held at 0 → ERR after 1 issue cycle plus 4 REQ cycles, `mem_req` drops, `err_MEM`=1.
- Back-to-back load 0x0020 then load 0x0022 with zero-wait memory → two separate requests, two `rd_valid_MEM` pulses with the correct data, 4 cycles total.
- Halt and reset: `halt_EX_MEM`=1 in IDLE → `halt_done`=1 next cycle and later `mem_en_EX_MEM` ignored. Asserting `rst`=0 in REQ clears all outputs immediately.
